periph_fabric: RTL and testbench

- Parametrised successor to the single-cycle peripheral bus.
- Registered MMIO fabric between the CPU peripheral port and N_SLOTS peripheral slots. Each slot is selected by page field i_addr[11:8].
- Adds a transaction FSM with held-select handshake, per-access timeout, decode-error detection, a built-in error status/capture register bank, and an error interrupt.
- Sits between the core's load/store unit and the timer/pario/uart/irq_ctrl instances.

---
 rtl/periph_fabric_pkg.sv | 26 ++
 rtl/periph_fabric_stat.sv | 66 ++++++
 rtl/periph_fabric.sv | 173 +++++++++++++++++
 tb/tb_periph_fabric.sv | 391 +++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/periph_fabric_pkg.sv
// Shared definitions for the peripheral MMIO fabric:
// page field, status bank layout and FSM encoding.
package periph_fabric_pkg;

  localparam int PAGE_HI = 11;
  localparam int PAGE_LO = 8;

  localparam logic [2:0] OFF_ERR_STAT = 3'd0;
  localparam logic [2:0] OFF_ERR_ADDR = 3'd1;
  localparam logic [2:0] OFF_ERR_CNT  = 3'd2;
  localparam logic [2:0] OFF_CTRL     = 3'd3;

  localparam int ST_TO  = 0;
  localparam int ST_DEC = 1;
  localparam int ST_WE  = 2;

  localparam int CTRL_IRQ_EN = 0;
  localparam int CTRL_TO_DIS = 1;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_ACCESS = 2'd1,
    S_RESP   = 2'd2
  } state_t;

endpackage

// File: rtl/periph_fabric_stat.sv
// Error status / capture bank: sticky error flags, last error
// address, saturating error count and control bits.
module periph_fabric_stat
  import periph_fabric_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        log_to,
  input  logic        log_dec,
  input  logic        log_we,
  input  logic [15:0] log_addr,
  input  logic        acc,
  input  logic        we,
  input  logic [2:0]  off,
  input  logic [15:0] wdata,
  output logic [15:0] rdata,
  output logic        irq,
  output logic        to_dis
);

  logic [2:0]  err_stat;
  logic [15:0] err_addr;
  logic [15:0] err_cnt;
  logic [1:0]  ctrl;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_stat <= '0;
      err_addr <= '0;
      err_cnt  <= '0;
      ctrl     <= '0;
    end else begin
      if (acc && we) begin
        case (off)
          OFF_ERR_STAT: err_stat[1:0] <= err_stat[1:0] & ~wdata[1:0];
          OFF_ERR_CNT:  err_cnt <= '0;
          OFF_CTRL:     ctrl <= wdata[1:0];
          default: ;
        endcase
      end
      if (log_to || log_dec) begin
        err_stat[ST_TO]  <= err_stat[ST_TO] | log_to;
        err_stat[ST_DEC] <= err_stat[ST_DEC] | log_dec;
        err_stat[ST_WE]  <= log_we;
        err_addr <= log_addr;
        if (err_cnt != 16'hFFFF)
          err_cnt <= err_cnt + 16'd1;
      end
    end
  end

  always_comb begin
    rdata = '0;
    case (off)
      OFF_ERR_STAT: rdata = {13'd0, err_stat};
      OFF_ERR_ADDR: rdata = err_addr;
      OFF_ERR_CNT:  rdata = err_cnt;
      OFF_CTRL:     rdata = {14'd0, ctrl};
      default:      rdata = '0;
    endcase
  end

  assign irq    = (err_stat[1:0] != 2'b00) && ctrl[CTRL_IRQ_EN];
  assign to_dis = ctrl[CTRL_TO_DIS];

endmodule

// File: rtl/periph_fabric.sv
// Registered MMIO fabric: page decode, held-select slave access
// with timeout, built-in status bank and error interrupt.
module periph_fabric
  import periph_fabric_pkg::*;
#(
  parameter int          N_SLOTS   = 4,
  parameter int          TIMEOUT   = 255,
  parameter logic [3:0]  STAT_PAGE = 4'hE,
  parameter int          SLOT_AW   = 4
) (
  input  logic                  i_clk,
  input  logic                  i_rst_n,
  input  logic [15:0]           i_addr,
  input  logic                  i_sel,
  input  logic                  i_we,
  input  logic                  i_re,
  input  logic [15:0]           i_wdata,
  output logic [15:0]           o_rdata,
  output logic                  o_rdy,
  output logic                  o_err,
  output logic [N_SLOTS-1:0]    o_s_sel,
  output logic                  o_s_we,
  output logic                  o_s_re,
  output logic [SLOT_AW-1:0]    o_s_addr,
  output logic [15:0]           o_s_wdata,
  input  logic [16*N_SLOTS-1:0] i_s_rdata,
  input  logic [N_SLOTS-1:0]    i_s_rdy,
  output logic                  o_err_irq
);

  state_t state, state_n;
  logic [15:0] cnt, cnt_n;
  logic [15:0] addr_q, addr_n;
  logic we_q, we_n;
  logic [N_SLOTS-1:0] s_sel_n;
  logic s_we_n, s_re_n;
  logic [SLOT_AW-1:0] s_addr_n;
  logic [15:0] s_wdata_n, rdata_n;
  logic rdy_n, err_n;

  logic [3:0] page;
  logic hit_slot, hit_stat, slot_rdy;
  logic [15:0] slot_rdata, st_rdata, log_addr;
  logic log_to, log_dec, log_we, st_acc, to_dis;

  assign page     = i_addr[PAGE_HI:PAGE_LO];
  assign hit_slot = 32'(page) < N_SLOTS;
  assign hit_stat = page == STAT_PAGE;
  assign slot_rdy = |(i_s_rdy & o_s_sel);

  always_comb begin
    slot_rdata = '0;
    for (int k = 0; k < N_SLOTS; k++)
      if (o_s_sel[k]) slot_rdata |= i_s_rdata[16*k +: 16];
  end

  always_comb begin
    state_n   = state;
    cnt_n     = cnt;
    addr_n    = addr_q;
    we_n      = we_q;
    s_sel_n   = o_s_sel;
    s_we_n    = o_s_we;
    s_re_n    = o_s_re;
    s_addr_n  = o_s_addr;
    s_wdata_n = o_s_wdata;
    rdy_n     = 1'b0;
    err_n     = 1'b0;
    rdata_n   = '0;
    log_to    = 1'b0;
    log_dec   = 1'b0;
    log_we    = we_q;
    log_addr  = addr_q;
    st_acc    = 1'b0;
    case (state)
      S_IDLE: if (i_sel) begin
        addr_n = i_addr;
        we_n   = i_we;
        unique case (1'b1)
          hit_slot: begin
            state_n   = S_ACCESS;
            cnt_n     = '0;
            s_sel_n   = N_SLOTS'(1) << page;
            s_we_n    = i_we;
            s_re_n    = i_re;
            s_addr_n  = i_addr[SLOT_AW-1:0];
            s_wdata_n = i_wdata;
          end
          hit_stat: begin
            st_acc  = 1'b1;
            state_n = S_RESP;
            rdy_n   = 1'b1;
            rdata_n = i_we ? 16'd0 : st_rdata;
          end
          default: begin
            log_dec  = 1'b1;
            log_we   = i_we;
            log_addr = i_addr;
            state_n  = S_RESP;
            rdy_n    = 1'b1;
            err_n    = 1'b1;
          end
        endcase
      end
      S_ACCESS: begin
        // A ready arriving on the expiry cycle still completes cleanly.
        if (slot_rdy || (!to_dis && cnt == 16'(TIMEOUT - 1))) begin
          state_n   = S_RESP;
          rdy_n     = 1'b1;
          err_n     = !slot_rdy;
          log_to    = !slot_rdy;
          rdata_n   = (slot_rdy && !we_q) ? slot_rdata : 16'd0;
          s_sel_n   = '0;
          s_we_n    = 1'b0;
          s_re_n    = 1'b0;
          s_addr_n  = '0;
          s_wdata_n = '0;
        end else begin
          cnt_n = cnt + 16'd1;
        end
      end
      S_RESP:  state_n = S_IDLE;
      default: state_n = S_IDLE;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state     <= S_IDLE;
      cnt       <= '0;
      addr_q    <= '0;
      we_q      <= 1'b0;
      o_s_sel   <= '0;
      o_s_we    <= 1'b0;
      o_s_re    <= 1'b0;
      o_s_addr  <= '0;
      o_s_wdata <= '0;
      o_rdy     <= 1'b0;
      o_err     <= 1'b0;
      o_rdata   <= '0;
    end else begin
      state     <= state_n;
      cnt       <= cnt_n;
      addr_q    <= addr_n;
      we_q      <= we_n;
      o_s_sel   <= s_sel_n;
      o_s_we    <= s_we_n;
      o_s_re    <= s_re_n;
      o_s_addr  <= s_addr_n;
      o_s_wdata <= s_wdata_n;
      o_rdy     <= rdy_n;
      o_err     <= err_n;
      o_rdata   <= rdata_n;
    end
  end

  periph_fabric_stat u_stat (
    .clk      (i_clk),
    .rst_n    (i_rst_n),
    .log_to   (log_to),
    .log_dec  (log_dec),
    .log_we   (log_we),
    .log_addr (log_addr),
    .acc      (st_acc),
    .we       (i_we),
    .off      (i_addr[3:1]),
    .wdata    (i_wdata),
    .rdata    (st_rdata),
    .irq      (o_err_irq),
    .to_dis   (to_dis)
  );

endmodule

// File: tb/tb_periph_fabric.sv
// Directed bench for periph_fabric (N_SLOTS=4, TIMEOUT=8).
// Inputs change and outputs are sampled on the falling edge.
module tb_periph_fabric;

  logic        i_clk = 0;
  logic        i_rst_n;
  logic [15:0] i_addr;
  logic        i_sel, i_we, i_re;
  logic [15:0] i_wdata;
  logic [15:0] o_rdata;
  logic        o_rdy, o_err;
  logic [3:0]  o_s_sel;
  logic        o_s_we, o_s_re;
  logic [3:0]  o_s_addr;
  logic [15:0] o_s_wdata;
  logic [63:0] i_s_rdata;
  logic [3:0]  i_s_rdy;
  logic        o_err_irq;

  int n_chk = 0;
  int n_fail = 0;
  int k;
  logic e;
  logic [15:0] r;

  always #5 i_clk = ~i_clk;

  periph_fabric #(
    .N_SLOTS(4), .TIMEOUT(8), .STAT_PAGE(4'hE), .SLOT_AW(4)
  ) dut (
    .i_clk(i_clk), .i_rst_n(i_rst_n), .i_addr(i_addr),
    .i_sel(i_sel), .i_we(i_we), .i_re(i_re), .i_wdata(i_wdata),
    .o_rdata(o_rdata), .o_rdy(o_rdy), .o_err(o_err),
    .o_s_sel(o_s_sel), .o_s_we(o_s_we), .o_s_re(o_s_re),
    .o_s_addr(o_s_addr), .o_s_wdata(o_s_wdata),
    .i_s_rdata(i_s_rdata), .i_s_rdy(i_s_rdy), .o_err_irq(o_err_irq)
  );

  // Issue one request and wait (bounded) for o_rdy; k=0 means no response.
  task automatic xact(input logic [15:0] a, input logic w,
                      input logic [15:0] d);
    @(negedge i_clk);
    i_addr = a; i_we = w; i_re = !w; i_wdata = d; i_sel = 1;
    k = 0; e = 0; r = 0;
    for (int c = 1; c <= 40; c++) begin
      @(negedge i_clk);
      if (o_rdy) begin
        k = c; e = o_err; r = o_rdata;
        break;
      end
    end
    i_sel = 0; i_we = 0; i_re = 0;
  endtask

  task automatic test_reset;
    i_rst_n = 0; i_sel = 0; i_we = 0; i_re = 0;
    i_addr = 0; i_wdata = 0; i_s_rdata = 0; i_s_rdy = 0;
    repeat (2) @(negedge i_clk);
    n_chk++;
    if ({o_rdy, o_err, o_rdata, o_s_sel, o_s_we, o_s_re, o_s_addr,
         o_s_wdata, o_err_irq} !== 0) begin
      n_fail++;
      $display("FAIL reset_outs got rdy=%b err=%b rd=%h sel=%b we=%b re=%b a=%h wd=%h irq=%b want all 0",
               o_rdy, o_err, o_rdata, o_s_sel, o_s_we, o_s_re,
               o_s_addr, o_s_wdata, o_err_irq);
    end
    i_rst_n = 1;
    for (int i = 0; i < 4; i++) begin
      xact(16'h0E00 | 16'(2 * i), 0, 0);
      n_chk++;
      if (k !== 1 || e !== 0 || r !== 0) begin
        n_fail++;
        $display("FAIL reset_stat%0d got k=%0d e=%b r=%h want k=1 e=0 r=0000",
                 i, k, e, r);
      end
    end
  endtask

  task automatic test_slot_read;
    @(negedge i_clk);
    i_s_rdy = 4'b0100;
    i_s_rdata = 64'h1111_BEEF_2222_3333;
    i_addr = 16'h0204; i_we = 0; i_re = 1; i_sel = 1;
    @(negedge i_clk);
    n_chk++;
    if (o_s_sel !== 4'b0100 || o_s_addr !== 4'h4 || o_s_re !== 1 ||
        o_s_we !== 0) begin
      n_fail++;
      $display("FAIL rd_access got sel=%b a=%h re=%b we=%b want 0100 4 1 0",
               o_s_sel, o_s_addr, o_s_re, o_s_we);
    end
    @(negedge i_clk);
    n_chk++;
    if (o_rdy !== 1 || o_rdata !== 16'hBEEF || o_err !== 0 ||
        o_s_sel !== 0) begin
      n_fail++;
      $display("FAIL rd_resp got rdy=%b rd=%h err=%b sel=%b want 1 beef 0 0000",
               o_rdy, o_rdata, o_err, o_s_sel);
    end
    i_sel = 0; i_re = 0; i_s_rdy = 0;
    @(negedge i_clk);
    n_chk++;
    if (o_rdy !== 0 || o_rdata !== 0) begin
      n_fail++;
      $display("FAIL rd_pulse got rdy=%b rd=%h want 0 0000", o_rdy, o_rdata);
    end
  endtask

  task automatic test_slot_write;
    int bad;
    bad = 0;
    @(negedge i_clk);
    i_s_rdy = 0;
    i_s_rdata = 64'h0000_0000_1234_0000;
    i_addr = 16'h0100; i_we = 1; i_re = 1; i_wdata = 16'h5A5A; i_sel = 1;
    for (int c = 1; c <= 5; c++) begin
      @(negedge i_clk);
      if (o_s_sel !== 4'b0010 || o_s_wdata !== 16'h5A5A || o_s_we !== 1 ||
          o_s_re !== 1 || o_rdy !== 0)
        bad++;
      if (c == 5) i_s_rdy = 4'b0010;
    end
    n_chk++;
    if (bad != 0) begin
      n_fail++;
      $display("FAIL wr_hold got %0d bad ACCESS cycles want 0", bad);
    end
    @(negedge i_clk);
    n_chk++;
    if (o_rdy !== 1 || o_err !== 0 || o_rdata !== 0) begin
      n_fail++;
      $display("FAIL wr_resp got rdy=%b err=%b rd=%h want 1 0 0000",
               o_rdy, o_err, o_rdata);
    end
    i_sel = 0; i_we = 0; i_re = 0; i_s_rdy = 0;
    @(negedge i_clk);
    n_chk++;
    if (o_rdy !== 0 || o_s_sel !== 0) begin
      n_fail++;
      $display("FAIL wr_pulse got rdy=%b sel=%b want 0 0000", o_rdy, o_s_sel);
    end
  endtask

  task automatic test_timeout_read;
    i_s_rdy = 0;
    xact(16'h0006, 0, 0);
    n_chk++;
    if (k !== 9 || e !== 1 || r !== 0) begin
      n_fail++;
      $display("FAIL to_resp got k=%0d e=%b r=%h want k=9 e=1 r=0000", k, e, r);
    end
    xact(16'h0E00, 0, 0);
    n_chk++;
    if (r !== 16'h0001) begin
      n_fail++;
      $display("FAIL to_stat got %h want 0001", r);
    end
    xact(16'h0E02, 0, 0);
    n_chk++;
    if (r !== 16'h0006) begin
      n_fail++;
      $display("FAIL to_addr got %h want 0006", r);
    end
    xact(16'h0E04, 0, 0);
    n_chk++;
    if (r !== 16'h0001 || o_err_irq !== 0) begin
      n_fail++;
      $display("FAIL to_cnt got cnt=%h irq=%b want 0001 0", r, o_err_irq);
    end
    xact(16'h0E06, 1, 16'h0001);
    n_chk++;
    if (k !== 1 || e !== 0 || o_err_irq !== 1) begin
      n_fail++;
      $display("FAIL to_irq got k=%0d e=%b irq=%b want 1 0 1", k, e, o_err_irq);
    end
  endtask

  task automatic test_decode;
    xact(16'h0900, 0, 0);
    n_chk++;
    if (k !== 1 || e !== 1 || r !== 0 || o_s_sel !== 0) begin
      n_fail++;
      $display("FAIL dec_resp got k=%0d e=%b r=%h sel=%b want 1 1 0000 0000",
               k, e, r, o_s_sel);
    end
    xact(16'h0E00, 0, 0);
    n_chk++;
    if (r !== 16'h0003) begin
      n_fail++;
      $display("FAIL dec_stat got %h want 0003", r);
    end
    xact(16'h0E02, 0, 0);
    n_chk++;
    if (r !== 16'h0900) begin
      n_fail++;
      $display("FAIL dec_addr got %h want 0900", r);
    end
    xact(16'h0E04, 0, 0);
    n_chk++;
    if (r !== 16'h0002) begin
      n_fail++;
      $display("FAIL dec_cnt got %h want 0002", r);
    end
    xact(16'h0E00, 1, 16'h0001);
    n_chk++;
    if (o_err_irq !== 1) begin
      n_fail++;
      $display("FAIL dec_irq_hold got %b want 1", o_err_irq);
    end
    xact(16'h0E00, 1, 16'h0002);
    n_chk++;
    if (o_err_irq !== 0) begin
      n_fail++;
      $display("FAIL dec_irq_clr got %b want 0", o_err_irq);
    end
    xact(16'h0E00, 0, 0);
    n_chk++;
    if (r !== 16'h0000) begin
      n_fail++;
      $display("FAIL dec_stat_clr got %h want 0000", r);
    end
    xact(16'h0E04, 1, 16'h1234);
    xact(16'h0E04, 0, 0);
    n_chk++;
    if (r !== 16'h0000) begin
      n_fail++;
      $display("FAIL cnt_clr got %h want 0000", r);
    end
  endtask

  task automatic test_timeout_write;
    i_s_rdy = 0;
    xact(16'h0300, 1, 16'hABCD);
    n_chk++;
    if (k !== 9 || e !== 1) begin
      n_fail++;
      $display("FAIL tow_resp got k=%0d e=%b want 9 1", k, e);
    end
    xact(16'h0E00, 0, 0);
    n_chk++;
    if (r !== 16'h0005) begin
      n_fail++;
      $display("FAIL tow_stat got %h want 0005", r);
    end
    xact(16'h0E02, 0, 0);
    n_chk++;
    if (r !== 16'h0300) begin
      n_fail++;
      $display("FAIL tow_addr got %h want 0300", r);
    end
  endtask

  task automatic test_rdy_at_expiry;
    @(negedge i_clk);
    i_s_rdy = 0;
    i_s_rdata = 64'h0000_0000_0000_1111;
    i_addr = 16'h0010; i_we = 0; i_re = 1; i_sel = 1;
    for (int c = 1; c <= 8; c++) begin
      @(negedge i_clk);
      if (c == 8) i_s_rdy = 4'b0001;
    end
    @(negedge i_clk);
    n_chk++;
    if (o_rdy !== 1 || o_err !== 0 || o_rdata !== 16'h1111) begin
      n_fail++;
      $display("FAIL race_resp got rdy=%b err=%b rd=%h want 1 0 1111",
               o_rdy, o_err, o_rdata);
    end
    i_sel = 0; i_re = 0; i_s_rdy = 0;
    xact(16'h0E04, 0, 0);
    n_chk++;
    if (r !== 16'h0001) begin
      n_fail++;
      $display("FAIL race_cnt got %h want 0001", r);
    end
  endtask

  task automatic test_to_dis;
    int seen;
    seen = 0;
    xact(16'h0E06, 1, 16'h0002);
    @(negedge i_clk);
    i_s_rdy = 0;
    i_addr = 16'h0000; i_we = 0; i_re = 1; i_sel = 1;
    for (int c = 1; c <= 20; c++) begin
      @(negedge i_clk);
      if (o_rdy) seen++;
    end
    n_chk++;
    if (seen != 0) begin
      n_fail++;
      $display("FAIL todis_wait got %0d rdy pulses want 0", seen);
    end
    i_s_rdy = 4'b0001;
    @(negedge i_clk);
    n_chk++;
    if (o_rdy !== 1 || o_err !== 0) begin
      n_fail++;
      $display("FAIL todis_resp got rdy=%b err=%b want 1 0", o_rdy, o_err);
    end
    i_sel = 0; i_re = 0; i_s_rdy = 0;
    xact(16'h0E06, 1, 16'h0000);
  endtask

  task automatic test_unused_offset;
    xact(16'h0E0A, 1, 16'hFFFF);
    n_chk++;
    if (k !== 1 || e !== 0) begin
      n_fail++;
      $display("FAIL unused_wr got k=%0d e=%b want 1 0", k, e);
    end
    xact(16'h0E0A, 0, 0);
    n_chk++;
    if (r !== 0 || e !== 0) begin
      n_fail++;
      $display("FAIL unused_rd got r=%h e=%b want 0000 0", r, e);
    end
    xact(16'h0E06, 0, 0);
    n_chk++;
    if (r !== 0) begin
      n_fail++;
      $display("FAIL unused_ctrl got %h want 0000", r);
    end
  endtask

  task automatic test_reset_mid;
    int seen;
    seen = 0;
    xact(16'h0E06, 1, 16'h0001);
    @(negedge i_clk);
    i_s_rdy = 0;
    i_addr = 16'h0208; i_we = 0; i_re = 1; i_sel = 1;
    repeat (3) @(negedge i_clk);
    n_chk++;
    if (o_s_sel !== 4'b0100) begin
      n_fail++;
      $display("FAIL mid_pre got sel=%b want 0100", o_s_sel);
    end
    i_rst_n = 0;
    #1;
    n_chk++;
    if (o_s_sel !== 0 || o_rdy !== 0 || o_s_re !== 0) begin
      n_fail++;
      $display("FAIL mid_abort got sel=%b rdy=%b re=%b want 0000 0 0",
               o_s_sel, o_rdy, o_s_re);
    end
    @(negedge i_clk);
    i_sel = 0; i_re = 0;
    i_rst_n = 1;
    for (int c = 0; c < 5; c++) begin
      @(negedge i_clk);
      if (o_rdy) seen++;
    end
    n_chk++;
    if (seen != 0) begin
      n_fail++;
      $display("FAIL mid_rdy got %0d rdy pulses want 0", seen);
    end
    for (int i = 0; i < 4; i++) begin
      xact(16'h0E00 | 16'(2 * i), 0, 0);
      n_chk++;
      if (r !== 0 || k !== 1) begin
        n_fail++;
        $display("FAIL mid_stat%0d got r=%h k=%0d want 0000 1", i, r, k);
      end
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset;
    test_slot_read;
    test_slot_write;
    test_timeout_read;
    test_decode;
    test_timeout_write;
    test_rdy_at_expiry;
    test_to_dis;
    test_unused_offset;
    test_reset_mid;
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
